// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths and host FSM states for the register-file port scheduler
package regfile_pkg;
    localparam int REG_AW = 6;
    localparam int REG_DW = 32;
    localparam int REG_HOST_MAXWAIT = 8;
    typedef enum logic [1:0] {H_IDLE, H_RD, H_ACK} host_st_e;
endpackage

// File: rtl/regfile_wbuf.sv
// regfile_wbuf: one-entry posted writeback buffer with forwarding comparators
module regfile_wbuf import regfile_pkg::*; #(
    parameter int AW = REG_AW,
    parameter int DW = REG_DW
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          wb_req_i,
    input  logic [AW-1:0] wb_addr_i,
    input  logic [DW-1:0] wb_data_i,
    input  logic          commit_i,
    input  logic [AW-1:0] rd_srca_i,
    input  logic [AW-1:0] rd_srcb_i,
    input  logic [AW-1:0] host_addr_i,
    output logic          wb_ack_o,
    output logic          valid_o,
    output logic [AW-1:0] addr_o,
    output logic [DW-1:0] data_o,
    output logic          match_a_o,
    output logic          match_b_o,
    output logic          match_h_o
);
    logic          valid_q, valid_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;

    // A commit frees the slot in the same cycle, so a new entry may replace it on the edge
    assign wb_ack_o = wb_req_i & (~valid_q | commit_i);

    always_comb begin
        valid_d = wb_ack_o | (valid_q & ~commit_i);
        addr_d  = wb_ack_o ? wb_addr_i : addr_q;
        data_d  = wb_ack_o ? wb_data_i : data_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign valid_o   = valid_q;
    assign addr_o    = addr_q;
    assign data_o    = data_q;
    assign match_a_o = valid_q & (addr_q == rd_srca_i);
    assign match_b_o = valid_q & (addr_q == rd_srcb_i);
    assign match_h_o = valid_q & (addr_q == host_addr_i);
endmodule

// File: rtl/regfile_sched.sv
// regfile_sched: shares the dual-port register RAM among pipeline reads, posted
// writebacks and host accesses, with starvation-bounded host service.
module regfile_sched import regfile_pkg::*; #(
    parameter int AW           = REG_AW,
    parameter int DW           = REG_DW,
    parameter int HOST_MAXWAIT = REG_HOST_MAXWAIT
) (
    input  logic          sys_clk,
    input  logic          resetl,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_srca,
    input  logic [AW-1:0] rd_srcb,
    output logic          rd_gnt,
    output logic          rd_valid,
    output logic [DW-1:0] rd_qa,
    output logic [DW-1:0] rd_qb,
    input  logic          wb_req,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic          wb_ack,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ack,
    output logic [DW-1:0] host_rdata,
    output logic [AW-1:0] ram_aa,
    output logic [AW-1:0] ram_ab,
    output logic [DW-1:0] ram_da,
    output logic [DW-1:0] ram_db,
    output logic          ram_nwea,
    output logic          ram_nweb,
    output logic          ram_clka,
    output logic          ram_clkb,
    input  logic [DW-1:0] ram_qa,
    input  logic [DW-1:0] ram_qb
);
    localparam int CW = $clog2(HOST_MAXWAIT + 1);

    logic          rd_req_g, wb_req_g, host_req_g;
    logic          wb_valid, commit, ma, mb, mh;
    logic [AW-1:0] wb_a;
    logic [DW-1:0] wb_d;
    logic          host_pend, force_wb, force_host, idle, host_iss, host_wr;
    logic [CW-1:0] cnt_q, cnt_d;
    host_st_e      state_q;
    logic          rd_valid_q, fa_q, fb_q, hf_q, host_ack_q;
    logic [DW-1:0] fd_q, hd_q, host_rdata_q;

    // Requests are masked while reset is asserted so every RAM pin sits idle
    assign rd_req_g   = rd_req & resetl;
    assign wb_req_g   = wb_req & resetl;
    assign host_req_g = host_req & resetl;

    regfile_wbuf #(.AW(AW), .DW(DW)) u_wbuf (
        .clk_i       (sys_clk),
        .rst_ni      (resetl),
        .wb_req_i    (wb_req_g),
        .wb_addr_i   (wb_addr),
        .wb_data_i   (wb_data),
        .commit_i    (commit),
        .rd_srca_i   (rd_srca),
        .rd_srcb_i   (rd_srcb),
        .host_addr_i (host_addr),
        .wb_ack_o    (wb_ack),
        .valid_o     (wb_valid),
        .addr_o      (wb_a),
        .data_o      (wb_d),
        .match_a_o   (ma),
        .match_b_o   (mb),
        .match_h_o   (mh)
    );

    always_comb begin
        host_pend  = host_req_g & (state_q == H_IDLE);
        force_wb   = wb_valid & wb_req_g;
        force_host = ~force_wb & host_pend & (cnt_q == CW'(HOST_MAXWAIT));
        rd_gnt     = ~force_wb & ~force_host & rd_req_g;
        idle       = ~force_wb & ~force_host & ~rd_req_g;
        // Port B is free for a commit whenever the pipeline does not own it
        commit     = wb_valid & ~rd_gnt;
        host_iss   = host_pend & ~(host_we & mh) & (force_host | idle);
        host_wr    = host_iss & host_we;
        cnt_d      = (~host_req_g | host_iss) ? '0 :
                     (host_pend && cnt_q != CW'(HOST_MAXWAIT)) ? cnt_q + 1'b1 : cnt_q;
    end

    assign ram_clka = rd_gnt | host_iss;
    assign ram_nwea = ~host_wr;
    assign ram_aa   = rd_gnt ? rd_srca : host_iss ? host_addr : '0;
    assign ram_da   = host_wr ? host_wdata : '0;
    assign ram_clkb = rd_gnt | commit;
    assign ram_nweb = ~commit;
    assign ram_ab   = rd_gnt ? rd_srcb : commit ? wb_a : '0;
    assign ram_db   = commit ? wb_d : '0;

    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            fa_q       <= 1'b0;
            fb_q       <= 1'b0;
            fd_q       <= '0;
        end else begin
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_gnt;
            if (rd_gnt) begin
                fa_q <= ma;
                fb_q <= mb;
                fd_q <= wb_d;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            state_q      <= H_IDLE;
            host_ack_q   <= 1'b0;
            hf_q         <= 1'b0;
            hd_q         <= '0;
            host_rdata_q <= '0;
        end else begin
            host_ack_q <= (state_q == H_RD) | host_wr;
            if (host_iss) begin
                hf_q <= mh;
                hd_q <= wb_d;
            end
            case (state_q)
                H_IDLE: if (host_iss) state_q <= host_we ? H_ACK : H_RD;
                H_RD: begin
                    host_rdata_q <= hf_q ? hd_q : ram_qa;
                    state_q      <= H_ACK;
                end
                default: state_q <= H_IDLE;
            endcase
        end
    end

    assign rd_valid   = rd_valid_q;
    assign rd_qa      = rd_valid_q ? (fa_q ? fd_q : ram_qa) : '0;
    assign rd_qb      = rd_valid_q ? (fb_q ? fd_q : ram_qb) : '0;
    assign host_ack   = host_ack_q;
    assign host_rdata = host_rdata_q;
endmodule
